adc_frame_fifo: RTL and testbench
=================================

# adc_frame_fifo

Single-clock, parametrised sample FIFO that buffers ADC samples and releases them to the FFT core as fixed-length frames. Writes are accepted one sample per cycle. The block raises `frame_ready` once a full frame is buffered. A one-cycle `frame_req` pulse then streams exactly `FRAME_LEN` samples back-to-back with start-of-frame and end-of-frame markers. It also adds water-level flags, overflow detection and an optional dropped-sample counter.

## Interface
- `DATA_WIDTH`, 12: sample width in bits.
- `DEPTH_WIDTH`, 11: address width; the FIFO depth is 2^DEPTH_WIDTH.
- `FRAME_LEN`, 1024: samples per frame; legal range 2 to 2^DEPTH_WIDTH.
- `ALMOST_FULL_NUM`, 1020: `almost_full` asserts when count >= this value.
- `ALMOST_EMPTY_NUM`, 4: `almost_empty` asserts when count <= this value.
- `clk`  in  1  the only clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write request.
- `wr_data`  in  DATA_WIDTH  write sample.
- `wr_full`  out  1  count == 2^DEPTH_WIDTH.
- `almost_full`  out  1  water-level flag.
- `almost_empty`  out  1  water-level flag.
- `water_level`  out  DEPTH_WIDTH+1  current occupancy.
- `overflow`  out  1  sticky; set when a write is dropped.
- `ovf_clr`  in  1  clears `overflow` (and `drop_cnt`, when compiled in).
- `frame_ready`  out  1  IDLE state and count >= FRAME_LEN.
- `frame_req`  in  1  starts a frame burst.
- `rd_data`  out  DATA_WIDTH  output sample.
- `rd_valid`  out  1  `rd_data` is valid this cycle.
- `rd_sof`  out  1  first sample of the frame.
- `rd_eof`  out  1  last sample of the frame.
- `drop_cnt`  out  16  dropped-sample count; present only with `ADC_FRAME_FIFO_DROP_CNT_EN`.

## Operation
- Storage is a RAM of 2^DEPTH_WIDTH x DATA_WIDTH with write pointer, read pointer and a count of DEPTH_WIDTH+1 bits.
  - Pointers are DEPTH_WIDTH bits wide and wrap naturally from 2^DEPTH_WIDTH-1 to 0.
- Write acceptance: a write is accepted when `wr_en` is high and `wr_full` is low.
  - A write while `wr_full` is high is dropped: no pointer change, `overflow` is set.
  - This holds even if a pop occurs in the same cycle.
- Pop: one entry per cycle while in the BURST state. Count update per cycle is +1 (write only), -1 (pop only), or 0 (both or neither).
- FSM has two states, IDLE and BURST.
  - IDLE to BURST: on `frame_req` while `frame_ready` is high. The beat counter loads 0 and the first pop occurs in that same cycle.
  - `frame_req` while `frame_ready` is low, or while in BURST, is ignored with no queuing.
  - BURST: one pop per cycle, unconditionally. Underflow is impossible because entry to BURST required count >= FRAME_LEN.
  - BURST to IDLE: in the cycle that pops beat FRAME_LEN-1.
- Output flags are combinational from count: `wr_full`, `almost_full`, `almost_empty`, `water_level`.
  - `frame_ready` is combinational from the state and count.
- `overflow`: clearing by `ovf_clr` takes priority over a set in the same cycle; the colliding drop is lost from the flag.

## Timing
- Read latency: a sample popped in cycle N appears on `rd_data` with `rd_valid`=1 in cycle N+1.
  - `rd_sof` accompanies beat 0; `rd_eof` accompanies beat FRAME_LEN-1.
  - `rd_valid` stays high for exactly FRAME_LEN consecutive cycles.
- Write-to-flag latency: an accepted write in cycle N is reflected in `water_level` from cycle N+1.
  - `frame_ready` can therefore assert one cycle after the FRAME_LEN-th write.
- Earliest next burst: a `frame_req` in the cycle after the last pop can be accepted if count >= FRAME_LEN.
- Reset values: count, pointers, `water_level`, `rd_valid`, `rd_sof`, `rd_eof`, `overflow`, `frame_ready`, `wr_full`, `almost_full` = 0; `drop_cnt` = 0; `almost_empty` = 1; FSM = IDLE. `rd_data` is don't-care while `rd_valid`=0.
- Reset mid-burst: the burst aborts and the FIFO empties. `rd_valid` is 0 from the cycle after `rst`, with no `rd_eof`.

## Configuration
- `ADC_FRAME_FIFO_DROP_CNT_EN` defined:
  - `drop_cnt` increments on each dropped write and saturates at 16'hFFFF.
  - It is cleared by `rst` or `ovf_clr`; `ovf_clr` wins over a same-cycle increment.
- Undefined: the `drop_cnt` port and its logic are absent; all other behaviour is identical.

## Test plan
- Fill/flags (DEPTH_WIDTH=4, FRAME_LEN=8, AF=14, AE=2): write 16 samples -> `water_level` steps 0..16; `almost_empty` drops when count reaches 3; `almost_full` rises at 14; `wr_full` rises at 16.
- Frame burst: write 0..9, pulse `frame_req` -> `rd_valid` high for 8 cycles, one cycle after the request, data 0..7, `rd_sof` with 0, `rd_eof` with 7; `water_level` ends at 2.
- Request gating: with count=7 pulse `frame_req` -> no `rd_valid`; a second `frame_req` issued mid-burst -> ignored, exactly 8 beats.
- Overflow: fill to 16, then write 3 more during a concurrent burst -> 3 samples dropped, `overflow`=1, `drop_cnt`=3 (macro on); `ovf_clr` -> both 0 the next cycle.
- Wrap-around: run 5 consecutive write-16/read-2-frames cycles -> data order preserved across the pointer wrap.
- Reset mid-burst: assert `rst` at beat 3 -> `rd_valid`=0 the next cycle, `water_level`=0, `almost_empty`=1, FSM=IDLE.

Source files
------------

// File: rtl/adc_frame_fifo.sv
// adc_frame_fifo: single-clock sample FIFO that collects ADC samples and
// releases them to the FFT core as fixed-length frames. Once FRAME_LEN
// samples are buffered, frame_ready rises. A frame_req pulse then streams
// one frame back-to-back, with start-of-frame and end-of-frame markers.
// Optional feature macro: ADC_FRAME_FIFO_DROP_CNT_EN adds the saturating
// drop_cnt output, which counts writes rejected while the FIFO was full.

module adc_frame_fifo #(
    parameter int DATA_WIDTH       = 12,
    parameter int DEPTH_WIDTH      = 11,
    parameter int FRAME_LEN        = 1024,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_WIDTH:0]  water_level,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic                  frame_ready,
    input  logic                  frame_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_sof,
    output logic                  rd_eof
`ifdef ADC_FRAME_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]           drop_cnt
`endif
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;

    localparam logic [DEPTH_WIDTH:0]   FULL_LVL  = (DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0]   AF_LVL    = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [DEPTH_WIDTH:0]   AE_LVL    = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
    localparam logic [DEPTH_WIDTH:0]   FRAME_LVL = (DEPTH_WIDTH+1)'(FRAME_LEN);
    localparam logic [DEPTH_WIDTH-1:0] LAST_BEAT = DEPTH_WIDTH'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH:0]   count;

    state_t                 state;
    state_t                 state_next;
    logic [DEPTH_WIDTH-1:0] beat;
    logic [DEPTH_WIDTH-1:0] beat_next;
    logic [DEPTH_WIDTH-1:0] beat_inc;

    logic                   pop;
    logic                   pop_first;
    logic                   pop_last;
    logic                   wr_accept;
    logic                   wr_drop;

    assign wr_full      = (count == FULL_LVL);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);
    assign water_level  = count;
    assign frame_ready  = (state == IDLE) && (count >= FRAME_LVL);

    // A full FIFO drops the write even if a pop frees a slot in the same cycle
    assign wr_accept = wr_en && !wr_full;
    assign wr_drop   = wr_en && wr_full;
    assign beat_inc  = beat + DEPTH_WIDTH'(1);

    // Next-state logic: beat holds the index of the most recent pop
    always_comb begin
        state_next = state;
        beat_next  = beat;
        pop        = 1'b0;
        pop_first  = 1'b0;
        pop_last   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_req && frame_ready) begin
                    pop        = 1'b1;
                    pop_first  = 1'b1;
                    beat_next  = '0;
                    state_next = BURST;
                end
            end
            BURST: begin
                pop       = 1'b1;
                beat_next = beat_inc;
                if (beat_inc == LAST_BEAT) begin
                    pop_last   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and beat register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + (DEPTH_WIDTH+1)'(1);
                2'b01:   count <= count - (DEPTH_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sample storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Read data register, a free-running payload qualified by rd_valid
    always_ff @(posedge clk) begin
        if (pop) begin
            rd_data <= mem[rd_ptr];
        end
    end

    // Output qualifiers, one cycle behind the pop
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_sof   <= 1'b0;
            rd_eof   <= 1'b0;
        end else begin
            rd_valid <= pop;
            rd_sof   <= pop_first;
            rd_eof   <= pop_last;
        end
    end

    // Sticky overflow; a clear beats a same-cycle drop
    always_ff @(posedge clk) begin
        if (rst || ovf_clr) begin
            overflow <= 1'b0;
        end else if (wr_drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef ADC_FRAME_FIFO_DROP_CNT_EN
    // Saturating dropped-sample counter; a clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || ovf_clr) begin
            drop_cnt <= '0;
        end else if (wr_drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adc_frame_fifo.sv
// tb_adc_frame_fifo: directed bench for adc_frame_fifo (depth 16, frame 8).
// A queue-based reference model tracks the FIFO contents and the frame
// in progress. Every cycle, one compare process checks all DUT outputs
// against the model. Directed sections add hand-computed expectations.

module tb_adc_frame_fifo;

    localparam int DW  = 12;
    localparam int AW  = 4;
    localparam int FL  = 8;
    localparam int AF  = 14;
    localparam int AE  = 2;
    localparam int DEP = 16;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_full;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   water_level;
    logic          overflow;
    logic          ovf_clr;
    logic          frame_ready;
    logic          frame_req;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_sof;
    logic          rd_eof;
`ifdef ADC_FRAME_FIFO_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Reference model state
    int q[$];
    int burst_left = 0;
    int beat_idx   = 0;
    bit e_valid    = 0;
    int e_data     = 0;
    bit e_sof      = 0;
    bit e_eof      = 0;
    bit m_ovf      = 0;
    int m_drop     = 0;

    adc_frame_fifo #(
        .DATA_WIDTH      (DW),
        .DEPTH_WIDTH     (AW),
        .FRAME_LEN       (FL),
        .ALMOST_FULL_NUM (AF),
        .ALMOST_EMPTY_NUM(AE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_full     (wr_full),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .water_level (water_level),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .frame_ready (frame_ready),
        .frame_req   (frame_req),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_sof      (rd_sof),
        .rd_eof      (rd_eof)
`ifdef ADC_FRAME_FIFO_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs shortly after a rising edge
    task automatic applyStimulus(input logic we, input int data, input logic req,
                                 input logic clr, input logic rs);
        @(posedge clk);
        #1;
        wr_en     = we;
        wr_data   = DW'(data);
        frame_req = req;
        ovf_clr   = clr;
        rst       = rs;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Behavioural model: a queue of samples plus the remaining beats of the frame
    always @(posedge clk) begin
        bit full_now;
        bit ready_now;
        if (rst) begin
            q.delete();
            burst_left = 0;
            beat_idx   = 0;
            e_valid    = 0;
            e_sof      = 0;
            e_eof      = 0;
            m_ovf      = 0;
            m_drop     = 0;
        end else begin
            full_now  = (q.size() == DEP);
            ready_now = (burst_left == 0) && (q.size() >= FL);
            if (burst_left == 0 && frame_req && ready_now) begin
                burst_left = FL;
                beat_idx   = 0;
            end
            if (burst_left > 0) begin
                e_valid = 1;
                e_data  = q.pop_front();
                e_sof   = (beat_idx == 0);
                e_eof   = (beat_idx == FL - 1);
                beat_idx++;
                burst_left--;
            end else begin
                e_valid = 0;
                e_sof   = 0;
                e_eof   = 0;
            end
            if (wr_en && !full_now) begin
                q.push_back(int'(wr_data));
            end
            if (ovf_clr) begin
                m_ovf  = 0;
                m_drop = 0;
            end else if (wr_en && full_now) begin
                m_ovf = 1;
                if (m_drop < 16'hFFFF) m_drop++;
            end
        end
    end

    // Compare all outputs against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("water_level", int'(water_level), q.size());
            checkOutput("wr_full", int'(wr_full), int'(q.size() == DEP));
            checkOutput("almost_full", int'(almost_full), int'(q.size() >= AF));
            checkOutput("almost_empty", int'(almost_empty), int'(q.size() <= AE));
            checkOutput("frame_ready", int'(frame_ready), int'(burst_left == 0 && q.size() >= FL));
            checkOutput("overflow", int'(overflow), int'(m_ovf));
            checkOutput("rd_valid", int'(rd_valid), int'(e_valid));
            checkOutput("rd_sof", int'(rd_sof), int'(e_sof));
            checkOutput("rd_eof", int'(rd_eof), int'(e_eof));
            if (e_valid) begin
                checkOutput("rd_data", int'(rd_data), e_data);
            end
`ifdef ADC_FRAME_FIFO_DROP_CNT_EN
            checkOutput("drop_cnt", int'(drop_cnt), m_drop);
`endif
        end
    end

    // Directed scenarios
    initial begin
        int beats;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = '0;
        frame_req = 1'b0;
        ovf_clr   = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1;

        // Reset values
        @(negedge clk);
        checkOutput("reset water_level", int'(water_level), 0);
        checkOutput("reset almost_empty", int'(almost_empty), 1);
        checkOutput("reset almost_full", int'(almost_full), 0);
        checkOutput("reset wr_full", int'(wr_full), 0);
        checkOutput("reset rd_valid", int'(rd_valid), 0);
        checkOutput("reset frame_ready", int'(frame_ready), 0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Fill and water-level flags
        $display("[TB] fill and flags");
        for (int i = 0; i < DEP; i++) begin
            applyStimulus(1'b1, 100 + i, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("fill water_level", int'(water_level), i);
            checkOutput("fill almost_empty", int'(almost_empty), int'(i <= 2));
            checkOutput("fill almost_full", int'(almost_full), int'(i >= 14));
        end
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("fill final level", int'(water_level), 16);
        checkOutput("fill wr_full", int'(wr_full), 1);

        // Frame burst with data 0..9 buffered
        $display("[TB] frame burst");
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, i, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checkOutput("burst rd_valid", int'(rd_valid), 1);
            checkOutput("burst rd_data", int'(rd_data), i);
            checkOutput("burst rd_sof", int'(rd_sof), int'(i == 0));
            checkOutput("burst rd_eof", int'(rd_eof), int'(i == FL - 1));
        end
        @(negedge clk);
        checkOutput("burst end rd_valid", int'(rd_valid), 0);
        checkOutput("burst end level", int'(water_level), 2);

        // Request gating: too few samples, then a mid-burst request
        $display("[TB] request gating");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 200 + i, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("gated rd_valid", int'(rd_valid), 0);
        end
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 300 + i, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
        beats = 0;
        for (int k = 0; k < 24; k++) begin
            applyStimulus(1'b0, 0, 1'(k == 3), 1'b0, 1'b0);
            @(negedge clk);
            if (rd_valid) beats++;
        end
        checkOutput("gated beat count", beats, FL);

        // Overflow and drop counting
        $display("[TB] overflow");
        doReset();
        for (int i = 0; i < DEP; i++) applyStimulus(1'b1, 400 + i, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 500, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 501, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 502, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 503, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 504, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ovf set", int'(overflow), 1);
        checkOutput("ovf level", int'(water_level), 10);
`ifdef ADC_FRAME_FIFO_DROP_CNT_EN
        checkOutput("drop count", int'(drop_cnt), 3);
`endif
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ovf cleared", int'(overflow), 0);
`ifdef ADC_FRAME_FIFO_DROP_CNT_EN
        checkOutput("drop cleared", int'(drop_cnt), 0);
`endif
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 600 + i, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 700, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("clr beats drop", int'(overflow), 0);

        // Wrap-around: five fill/two-frame rounds
        $display("[TB] wrap-around");
        doReset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < DEP; i++) applyStimulus(1'b1, r * 16 + i + 1, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 7; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 10; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        checkOutput("wrap drained", int'(water_level), 0);

        // Reset mid-burst at beat 3
        $display("[TB] reset mid-burst");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 800 + i, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("abort rd_valid", int'(rd_valid), 0);
        checkOutput("abort rd_eof", int'(rd_eof), 0);
        checkOutput("abort level", int'(water_level), 0);
        checkOutput("abort almost_empty", int'(almost_empty), 1);
        for (int i = 0; i < FL; i++) applyStimulus(1'b1, 900 + i, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("post-abort sof", int'(rd_sof), 1);
        checkOutput("post-abort data", int'(rd_data), 900);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
